// File: rtl/trace_uart_streamer_pkg.sv
// Shared types and constants for the commit-trace UART streamer.
// No logic of its own; pure declarations and two small combinational helpers.
// Helpers are side-effect free and carry no handshake.
package trace_uart_streamer_pkg;

    localparam logic [1:0] KIND_NONE  = 2'd0;
    localparam logic [1:0] KIND_REG   = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;
    localparam logic [1:0] KIND_LOAD  = 2'd3;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    // PC is kept in a separate, PC_W-wide store because its width is a module parameter.
    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] inst;
        logic [31:0] data;
        logic [31:0] addr;
    } trace_rec_t;

    function automatic logic [7:0] kind_byte(input logic [1:0] kind, input logic [4:0] rd);
        return {kind, 1'b0, rd};
    endfunction

    // mode 0: everything, 1: architectural effects only, 2: stores only, 3: capture off
    function automatic logic pass_mode(input logic [1:0] mode, input logic [1:0] kind);
        logic ok;
        case (mode)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (kind == KIND_REG) || (kind == KIND_LOAD) || (kind == KIND_STORE);
            2'd2:    ok = (kind == KIND_STORE);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/trace_uart_streamer_if.sv
// Commit (retire) bus from the core into the trace streamer.
// Zero latency: plain wires, sampled by the consumer in the retire cycle.
// No backpressure: the core never stalls; the consumer drops what it cannot hold.
interface trace_uart_streamer_if #(parameter int PC_W = 16);

    logic            commit_valid;
    logic [1:0]      commit_kind;
    logic [PC_W-1:0] commit_pc;
    logic [31:0]     commit_inst;
    logic [4:0]      commit_rd;
    logic [31:0]     commit_data;
    logic [31:0]     commit_addr;

    modport master (
        output commit_valid, commit_kind, commit_pc, commit_inst,
               commit_rd, commit_data, commit_addr
    );

    modport slave (
        input  commit_valid, commit_kind, commit_pc, commit_inst,
               commit_rd, commit_data, commit_addr
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 serial transmitter for one byte per start strobe, idle line high.
// Line goes low one cycle after start; frame is 10*CLKS_PER_BIT cycles, done in last stop cycle.
// start is ignored while busy; caller must wait for done (or !busy) before the next byte.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          bit_end;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    // Pulse during the final cycle of the stop bit so the next byte can follow with one cycle gap.
    assign done    = busy && bit_end && (bit_cnt == 4'd9);

    // Bit timer and shifter: bit_cnt 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tx      <= 1'b1;
            busy    <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (!busy) begin
            if (start) begin
                tx      <= 1'b0;
                busy    <= 1'b1;
                clk_cnt <= '0;
                bit_cnt <= '0;
                shreg   <= {1'b1, data};
            end
        end else if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                busy <= 1'b0;
                tx   <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/trace_uart_streamer.sv
// Filters RV32I retire events, queues them and streams fixed-length binary records over UART.
// Start bit falls 3 cycles after a push into an empty idle unit; records back-to-back via one LOAD cycle.
// No backpressure to the core: commits arriving with the queue full are dropped and counted.
module trace_uart_streamer
    import trace_uart_streamer_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int DROP_W       = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    trace_uart_streamer_if.slave  cif,
    input  logic [1:0]            mode,
    output logic                  uart_tx,
    output logic                  fifo_full,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int N     = 14 + PC_W / 8;
    localparam int SH_W  = 8 * N;
    localparam int IDX_W = 5;

    // ---------------- filter ----------------
    logic [1:0] eff_kind;
    logic       accept;

    // A register write to x0 has no architectural effect, so it is traced as NONE.
    always_comb begin
        eff_kind = cif.commit_kind;
        if (cif.commit_kind == KIND_REG && cif.commit_rd == 5'd0) begin
            eff_kind = KIND_NONE;
        end
        accept = cif.commit_valid && pass_mode(mode, eff_kind);
    end

    // ---------------- record queue ----------------
    trace_rec_t      mem    [DEPTH];
    logic [PC_W-1:0] mem_pc [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            empty;
    logic            push;
    logic            pop;
    trace_rec_t      new_rec;
    trace_rec_t      head;
    logic [PC_W-1:0] head_pc;

    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    // A pop in the same cycle frees a slot, so a full queue can still take the new record.
    assign push      = accept && (!fifo_full || pop);

    assign new_rec = '{kind: eff_kind, rd: cif.commit_rd, inst: cif.commit_inst,
                       data: cif.commit_data, addr: cif.commit_addr};
    assign head    = mem[rd_ptr[AW-1:0]];
    assign head_pc = mem_pc[rd_ptr[AW-1:0]];

    // Storage is unreset: the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]]    <= new_rec;
            mem_pc[wr_ptr[AW-1:0]] <= cif.commit_pc;
        end
    end

    // Pointer update with an extra wrap bit so all DEPTH slots are usable.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Saturating count of records lost to a full queue.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            drop_count <= '0;
        end else if (accept && fifo_full && !pop && (drop_count != {DROP_W{1'b1}})) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    // ---------------- record FSM ----------------
    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [SH_W-1:0]  shreg;
    logic             uart_start;
    logic             tx_busy;
    logic             tx_done;

    // Next state and strobes; the queue is popped only in LOAD.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        uart_start = 1'b0;
        case (state)
            IDLE: if (!empty) next_state = LOAD;
            LOAD: begin
                pop        = 1'b1;
                next_state = SEND;
            end
            SEND: if (!tx_busy) begin
                uart_start = 1'b1;
                next_state = WAIT;
            end
            WAIT: if (tx_done) begin
                next_state = (idx == IDX_W'(N - 1)) ? IDLE : SEND;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register plus the byte shifter: byte 0 of the record sits in shreg[7:0].
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= next_state;
            if (state == LOAD) begin
                shreg <= {head.addr, head.data, head.inst, head_pc,
                          kind_byte(head.kind, head.rd), SYNC_BYTE};
                idx   <= '0;
            end else if (state == WAIT && tx_done) begin
                shreg <= shreg >> 8;
                idx   <= idx + 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .start (uart_start),
        .data  (shreg[7:0]),
        .tx    (uart_tx),
        .busy  (tx_busy),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_trace_uart_streamer.sv
`timescale 1ns/1ps
module tb_trace_uart_streamer;
    import trace_uart_streamer_pkg::*;

    localparam int PC_W = 16;
    localparam int DEPTH = 4;
    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        rstn2 = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        uart_tx, fifo_full, uart_tx2, fifo_full2;
    logic [15:0] drop_count;
    logic [1:0]  drop2;

    trace_uart_streamer_if #(.PC_W(PC_W)) cif ();

    trace_uart_streamer #(.PC_W(PC_W), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .DROP_W(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .cif(cif), .mode(mode),
        .uart_tx(uart_tx), .fifo_full(fifo_full), .drop_count(drop_count));

    trace_uart_streamer #(.PC_W(PC_W), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .DROP_W(2)) dut2 (
        .CLK(CLK), .RSTN(rstn2), .cif(cif), .mode(mode),
        .uart_tx(uart_tx2), .fifo_full(fifo_full2), .drop_count(drop2));

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned push_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // UART receiver: k counts negedges from start detection; samples at the middle of each bit.
    logic [7:0]  rxq [$];
    int unsigned rxt [$];
    logic [3:0]  rxs [$];
    logic [7:0]  expq [$];
    logic        rx_busy = 1'b0;
    int          rx_k = 0;
    logic [7:0]  rx_byte = 8'h00;
    logic [3:0]  rx_smp = 4'h0;
    int unsigned rx_t = 0;
    int          framing_err = 0;

    always @(negedge CLK) begin
        if (!RSTN) begin
            rx_busy <= 1'b0;
            rx_k    <= 0;
        end else if (!rx_busy) begin
            if (uart_tx == 1'b0) begin
                rx_busy <= 1'b1;
                rx_k    <= 1;
                rx_t    <= cyc;
            end
        end else begin
            rx_k <= rx_k + 1;
            if (rx_k == 3) rx_smp[3] <= uart_tx;
            if (rx_k == 4) rx_smp[2] <= uart_tx;
            if (rx_k == 7) rx_smp[1] <= uart_tx;
            if (rx_k == 8) rx_smp[0] <= uart_tx;
            if (rx_k >= 6 && rx_k <= 34 && (rx_k % 4) == 2) rx_byte[(rx_k - 6) / 4] <= uart_tx;
            if (rx_k == 38) begin
                if (uart_tx !== 1'b1) framing_err <= framing_err + 1;
                rxq.push_back(rx_byte);
                rxt.push_back(rx_t);
                rxs.push_back(rx_smp);
                rx_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic commit(input logic [1:0] k, input logic [4:0] rd, input logic [15:0] pc,
                          input logic [31:0] inst, input logic [31:0] data, input logic [31:0] addr);
        cif.commit_valid = 1'b1;
        cif.commit_kind  = k;
        cif.commit_rd    = rd;
        cif.commit_pc    = pc;
        cif.commit_inst  = inst;
        cif.commit_data  = data;
        cif.commit_addr  = addr;
        @(posedge CLK);
        #1;
        push_cyc = cyc;
        cif.commit_valid = 1'b0;
    endtask

    task automatic exp_rec(input logic [7:0] kb, input logic [15:0] pc, input logic [31:0] inst,
                           input logic [31:0] data, input logic [31:0] addr);
        expq.push_back(8'hA5);
        expq.push_back(kb);
        expq.push_back(pc[7:0]);
        expq.push_back(pc[15:8]);
        for (int i = 0; i < 4; i++) expq.push_back(inst[8*i +: 8]);
        for (int i = 0; i < 4; i++) expq.push_back(data[8*i +: 8]);
        for (int i = 0; i < 4; i++) expq.push_back(addr[8*i +: 8]);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            @(posedge CLK);
            #1;
            k++;
        end
        chk({tag, "_timeout"}, 32'(rxq.size() >= n), 32'd1);
    endtask

    task automatic clear_rx();
        rxq.delete();
        rxt.delete();
        rxs.delete();
        expq.delete();
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < rxq.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(rxq[i]), 32'(expq[i]));
        end
        clear_rx();
    endtask

    initial begin
        cif.commit_valid = 1'b0;
        cif.commit_kind  = KIND_NONE;
        cif.commit_rd    = 5'd0;
        cif.commit_pc    = '0;
        cif.commit_inst  = '0;
        cif.commit_data  = '0;
        cif.commit_addr  = '0;

        // reset state
        idle(3);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        RSTN = 1'b1;
        idle(2);

        // single REG commit, mode 0
        mode = 2'd0;
        commit(KIND_REG, 5'd1, 16'h0104, 32'h00a00093, 32'h0000000a, 32'h00000000);
        exp_rec(8'h41, 16'h0104, 32'h00a00093, 32'h0000000a, 32'h00000000);
        wait_bytes(16, 1500, "single");
        chk("single_latency", (rxt.size() > 0) ? (rxt[0] - push_cyc) : 32'hffffffff, 32'd3);
        chk("single_bit_shape", (rxs.size() > 0) ? 32'(rxs[0]) : 32'hffffffff, 32'h6);
        idle(150);
        check_rx("single");

        // mode 1: x0 write and non-effect retire are filtered
        mode = 2'd1;
        commit(KIND_REG, 5'd0, 16'h0110, 32'h00000013, 32'h00000005, 32'h0);
        commit(KIND_NONE, 5'd0, 16'h0114, 32'hfe000ee3, 32'h0, 32'h0);
        idle(150);
        chk("mode1_bytes", rxq.size(), 32'd0);
        chk("mode1_drop", 32'(drop_count), 32'd0);

        // mode 3: capture off
        mode = 2'd3;
        commit(KIND_STORE, 5'd0, 16'h0118, 32'h00112023, 32'h1, 32'h100);
        idle(150);
        chk("mode3_bytes", rxq.size(), 32'd0);

        // mode 2: only the store survives
        mode = 2'd2;
        commit(KIND_STORE, 5'd0, 16'h0200, 32'h0551a023, 32'h00000055, 32'h0001f9a0);
        commit(KIND_REG, 5'd2, 16'h0204, 32'h00100113, 32'h1, 32'h0);
        commit(KIND_REG, 5'd3, 16'h0208, 32'h00200193, 32'h2, 32'h0);
        commit(KIND_REG, 5'd4, 16'h020c, 32'h00300213, 32'h3, 32'h0);
        exp_rec(8'h80, 16'h0200, 32'h0551a023, 32'h00000055, 32'h0001f9a0);
        wait_bytes(16, 1500, "store");
        idle(150);
        check_rx("store");

        // burst of 7 back-to-back commits into a 4-deep queue
        mode = 2'd0;
        for (int i = 0; i < 7; i++) begin
            commit((i % 2 == 1) ? KIND_LOAD : KIND_REG, 5'(i + 1), 16'(16'h1000 + 4 * i),
                   32'(32'h11110000 + i), 32'(32'h22220000 + i), 32'(32'h33330000 + i));
        end
        for (int i = 0; i < 5; i++) begin
            exp_rec((i % 2 == 1) ? 8'(8'hC0 + i + 1) : 8'(8'h40 + i + 1), 16'(16'h1000 + 4 * i),
                    32'(32'h11110000 + i), 32'(32'h22220000 + i), 32'(32'h33330000 + i));
        end
        chk("burst_full", 32'(fifo_full), 32'd1);
        chk("burst_drop", 32'(drop_count), 32'd2);
        wait_bytes(15, 1500, "burst_rec0");
        chk("burst_full_until_pop", 32'(fifo_full), 32'd1);
        wait_bytes(16, 200, "burst_rec0_end");
        idle(10);
        chk("burst_full_after_pop", 32'(fifo_full), 32'd0);
        wait_bytes(80, 6000, "burst_all");
        idle(150);
        check_rx("burst");
        chk("burst_drop_final", 32'(drop_count), 32'd2);

        // asynchronous reset in the middle of a data bit of the second record
        commit(KIND_REG, 5'd5, 16'h2100, 32'haaaa0001, 32'h1, 32'h0);
        commit(KIND_REG, 5'd6, 16'h2200, 32'haaaa0002, 32'h2, 32'h0);
        commit(KIND_REG, 5'd7, 16'h2300, 32'haaaa0003, 32'h3, 32'h0);
        wait_bytes(18, 2500, "rst_pre");
        begin
            int k = 0;
            while (uart_tx !== 1'b0 && k < 100) begin
                @(posedge CLK);
                #1;
                k++;
            end
        end
        idle(6);
        chk("pre_rst_tx_low", 32'(uart_tx), 32'd0);
        chk("pre_rst_drop", 32'(drop_count), 32'd2);
        RSTN = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(uart_tx), 32'd1);
        chk("mid_rst_full", 32'(fifo_full), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        idle(3);
        RSTN = 1'b1;
        clear_rx();
        idle(2);
        commit(KIND_LOAD, 5'd3, 16'h3344, 32'h0000a183, 32'hdeadbeef, 32'h0000ab10);
        exp_rec(8'hC3, 16'h3344, 32'h0000a183, 32'hdeadbeef, 32'h0000ab10);
        wait_bytes(16, 1500, "post_rst");
        idle(200);
        check_rx("post_rst");

        // saturating drop counter on the 2-bit build
        rstn2 = 1'b1;
        idle(2);
        for (int i = 0; i < 7; i++) begin
            commit(KIND_REG, 5'd1, 16'h4000, 32'(i), 32'(i), 32'h0);
        end
        chk("sat_drop_two", 32'(drop2), 32'd2);
        chk("sat_full", 32'(fifo_full2), 32'd1);
        commit(KIND_REG, 5'd1, 16'h4000, 32'h7, 32'h7, 32'h0);
        chk("sat_drop_three", 32'(drop2), 32'd3);
        commit(KIND_REG, 5'd1, 16'h4000, 32'h8, 32'h8, 32'h0);
        commit(KIND_REG, 5'd1, 16'h4000, 32'h9, 32'h9, 32'h0);
        chk("sat_drop_hold", 32'(drop2), 32'd3);

        chk("framing", framing_err, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
